// File: rtl/vcore_mem_pkg.sv
// Shared definitions for the vcore data-memory responder: FSM encoding,
// data/bus widths and the wait-state counter range.
package vcore_mem_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned BUS_ADDR_W = 16;
  localparam int unsigned WAIT_MAX   = 15;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/vcore_dmem_responder_if.sv
// Core <-> data-memory request/response bus.
//   master: core side (drives enable/write/addr/wdata, samples rdata/valid)
//   slave : responder side
interface vcore_dmem_responder_if;
  import vcore_mem_pkg::*;

  logic                  mem_enable_i;
  logic                  mem_write_i;
  logic [BUS_ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0]     mem_wdata_i;
  logic [DATA_W-1:0]     mem_rdata_o;
  logic                  mem_valid_o;

  modport master (
    output mem_enable_i, mem_write_i, mem_addr_i, mem_wdata_i,
    input  mem_rdata_o, mem_valid_o
  );

  modport slave (
    input  mem_enable_i, mem_write_i, mem_addr_i, mem_wdata_i,
    output mem_rdata_o, mem_valid_o
  );
endinterface

// File: rtl/vcore_dmem_array.sv
// Word storage for the data-memory responder (not reset).
//   i_rd_addr / o_rd_data_c : asynchronous read port
//   i_wr_en / i_wr_addr / i_wr_data : functional write port
//   i_init_we / i_init_addr / i_init_data : backdoor write port
// A functional write to the same word on the same edge beats the backdoor.
module vcore_dmem_array
  import vcore_mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic [ADDR_BITS-1:0] i_rd_addr,
  output logic [DATA_W-1:0]    o_rd_data_c,
  input  logic                 i_wr_en,
  input  logic [ADDR_BITS-1:0] i_wr_addr,
  input  logic [DATA_W-1:0]    i_wr_data,
  input  logic                 i_init_we,
  input  logic [ADDR_BITS-1:0] i_init_addr,
  input  logic [DATA_W-1:0]    i_init_data
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [DATA_W-1:0] r_mem [DEPTH];

  assign o_rd_data_c = r_mem[i_rd_addr];

  // Functional write is applied last so it wins a same-word collision.
  always_ff @(posedge clk) begin
    if (i_init_we) r_mem[i_init_addr] <= i_init_data;
    if (i_wr_en)   r_mem[i_wr_addr]   <= i_wr_data;
  end

endmodule

// File: rtl/vcore_dmem_responder.sv
// Data-memory responder with programmable wait states.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : slave side of the core request/response bus
//   init_*_i     : backdoor word write into storage
//   proto_err_o  : sticky protocol-violation flag
module vcore_dmem_responder
  import vcore_mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  vcore_dmem_responder_if.slave  bus,
  input  logic                   init_we_i,
  input  logic [ADDR_BITS-1:0]   init_addr_i,
  input  logic [DATA_W-1:0]      init_data_i,
  output logic                   proto_err_o
);

  localparam logic [CNT_W-1:0] LP_CNT_INIT =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  dmem_state_e            r_state, w_state_n;
  logic [CNT_W-1:0]       r_cnt, w_cnt_n;
  logic                   r_write, w_write_n;
  logic [ADDR_BITS-1:0]   r_idx, w_idx_n;
  logic [DATA_W-1:0]      r_wdata, w_wdata_n;
  logic [DATA_W-1:0]      r_rdata, w_rdata_n;
  logic                   r_valid;
  logic                   r_proto_err, w_proto_err_n;

  logic [ADDR_BITS-1:0]   w_idx;
  logic [ADDR_BITS-1:0]   w_rd_addr;
  logic [DATA_W-1:0]      w_rd_data;
  logic                   w_mismatch;
  logic                   w_func_we;
  logic                   w_unused_addr;

  // Byte address -> word index; bit 0 and bits above the array alias away.
  assign w_idx         = bus.mem_addr_i[ADDR_BITS:1];
  assign w_unused_addr = &{1'b0, bus.mem_addr_i[0], bus.mem_addr_i[BUS_ADDR_W-1:ADDR_BITS+1]};

  assign w_mismatch = (bus.mem_write_i != r_write) || (w_idx != r_idx) ||
                      (r_write && (bus.mem_wdata_i != r_wdata));

  // Write lands on the edge that ends RESP.
  assign w_func_we = (r_state == ST_RESP) && r_write;

  vcore_dmem_array #(.ADDR_BITS(ADDR_BITS)) u_array (
    .clk         (clk),
    .i_rd_addr   (w_rd_addr),
    .o_rd_data_c (w_rd_data),
    .i_wr_en     (w_func_we),
    .i_wr_addr   (r_idx),
    .i_wr_data   (r_wdata),
    .i_init_we   (init_we_i),
    .i_init_addr (init_addr_i),
    .i_init_data (init_data_i)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_idx       <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_valid     <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_write     <= w_write_n;
      r_idx       <= w_idx_n;
      r_wdata     <= w_wdata_n;
      r_rdata     <= w_rdata_n;
      r_valid     <= (w_state_n == ST_RESP);
      r_proto_err <= w_proto_err_n;
    end
  end

  // Next-state, request latch and error detection.
  always_comb begin
    w_state_n     = r_state;
    w_cnt_n       = r_cnt;
    w_write_n     = r_write;
    w_idx_n       = r_idx;
    w_wdata_n     = r_wdata;
    w_rdata_n     = r_rdata;
    w_proto_err_n = r_proto_err;
    w_rd_addr     = r_idx;

    case (r_state)
      ST_IDLE: begin
        // With zero wait states RESP is entered straight from IDLE, so read
        // through the live index rather than the not-yet-latched one.
        w_rd_addr = w_idx;
        if (bus.mem_enable_i) begin
          w_write_n = bus.mem_write_i;
          w_idx_n   = w_idx;
          w_wdata_n = bus.mem_wdata_i;
          if (WAIT_CYCLES == 0) begin
            w_state_n = ST_RESP;
          end else begin
            w_state_n = ST_WAIT;
            w_cnt_n   = LP_CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (!bus.mem_enable_i) begin
          w_state_n     = ST_IDLE;
          w_cnt_n       = '0;
          w_proto_err_n = 1'b1;
        end else begin
          if (w_mismatch) w_proto_err_n = 1'b1;
          if (r_cnt == '0) w_state_n = ST_RESP;
          else             w_cnt_n   = r_cnt - CNT_W'(1);
        end
      end
      ST_RESP: begin
        w_state_n = ST_IDLE;
        if (bus.mem_enable_i && w_mismatch) w_proto_err_n = 1'b1;
      end
      default: w_state_n = ST_IDLE;
    endcase

    // RESP is only ever entered from IDLE/WAIT: capture read data on entry.
    if ((w_state_n == ST_RESP) && (r_state != ST_RESP)) w_rdata_n = w_rd_data;
  end

  assign bus.mem_rdata_o = r_rdata;
  assign bus.mem_valid_o = r_valid;
  assign proto_err_o     = r_proto_err;

endmodule
